// File: rtl/usb_rx_pkg.sv
// Shared types and defaults for the USB receive bit-recovery front end.
// Line states, recovery FSM states and the pad-pair decode helper.
package usb_rx_pkg;

   localparam int SAMPLES_PER_BIT = 8;
   localparam int STUFF_LIMIT     = 6;

   typedef enum logic [1:0] {
      LS_J,
      LS_K,
      LS_SE0,
      LS_SE1
   } line_state_t;

   typedef enum logic [2:0] {
      IDLE,
      ACTIVE,
      EOP1,
      EOP2,
      ERROR
   } bitrec_state_t;

   function automatic line_state_t decode_line(logic dp, logic dm);
      line_state_t ls;
      unique case ({dp, dm})
         2'b10:   ls = LS_J;
         2'b01:   ls = LS_K;
         2'b00:   ls = LS_SE0;
         default: ls = LS_SE1;
      endcase
      return ls;
   endfunction

endpackage

// File: rtl/usb_rx_bit_recovery_if.sv
// Recovered bit stream and framing flags from the bit-recovery stage.
// master drives the stream, slave is the byte assembler / PID logic.
interface usb_rx_bit_recovery_if;

   logic bit_out;
   logic bit_valid;
   logic rx_active;
   logic eop;
   logic stuff_error;
   logic line_error;

   modport master (
      output bit_out,
      output bit_valid,
      output rx_active,
      output eop,
      output stuff_error,
      output line_error
   );

   modport slave (
      input bit_out,
      input bit_valid,
      input rx_active,
      input eop,
      input stuff_error,
      input line_error
   );

endinterface

// File: rtl/usb_line_sync.sv
// Two-flop pad synchronizers plus line-state decode and D+ edge flag.
// Idle (J) is the reset value so reset never looks like a K edge.
module usb_line_sync
   import usb_rx_pkg::*;
(
   input  logic        clk,
   input  logic        n_rst,
   input  logic        d_plus_in,
   input  logic        d_minus_in,
   output line_state_t line_state,
   output logic        line_edge
);

   logic [1:0] dp_sync;
   logic [1:0] dm_sync;
   logic       dp_prev;

   always_ff @(posedge clk) begin
      if (n_rst) begin
         dp_sync <= 2'b11;
         dm_sync <= 2'b00;
         dp_prev <= 1'b1;
      end else begin
         dp_sync <= {dp_sync[0], d_plus_in};
         dm_sync <= {dm_sync[0], d_minus_in};
         dp_prev <= dp_sync[1];
      end
   end

   assign line_state = decode_line(dp_sync[1], dm_sync[1]);

   // Entering SE0 must not re-align the bit clock.
   assign line_edge = (dp_sync[1] != dp_prev) &&
                      (line_state != LS_SE0);

endmodule

// File: rtl/usb_rx_bit_recovery.sv
// USB receive bit recovery: phase tracking, NRZI decode, unstuffing,
// EOP detection and error framing on top of the synchronized line.
module usb_rx_bit_recovery #(
   parameter int SAMPLES_PER_BIT = usb_rx_pkg::SAMPLES_PER_BIT,
   parameter int STUFF_LIMIT     = usb_rx_pkg::STUFF_LIMIT
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    d_plus_in,
   input  logic                    d_minus_in,
   usb_rx_bit_recovery_if.master   rx
);

   import usb_rx_pkg::*;

   localparam int CW = $clog2(SAMPLES_PER_BIT);
   localparam int OW = $clog2(STUFF_LIMIT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(SAMPLES_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_MID = CW'(SAMPLES_PER_BIT / 2);
   localparam logic [OW-1:0] ONES_LIM = OW'(STUFF_LIMIT);

   line_state_t   line_state;
   logic          line_edge;
   logic [CW-1:0] cnt_q;
   logic          sample;
   logic          nrzi;

   bitrec_state_t state_q, state_d;
   line_state_t   prev_q, prev_d;
   logic [OW-1:0] ones_q, ones_d;
   logic          err_se0_q, err_se0_d;

   logic bit_q, bit_d;
   logic valid_q, valid_d;
   logic eop_q, eop_d;
   logic serr_q, serr_d;
   logic lerr_q, lerr_d;

   usb_line_sync u_line_sync (
      .clk        (clk),
      .n_rst      (n_rst),
      .d_plus_in  (d_plus_in),
      .d_minus_in (d_minus_in),
      .line_state (line_state),
      .line_edge  (line_edge)
   );

   always_ff @(posedge clk) begin
      if (n_rst)
         cnt_q <= '0;
      else if (line_edge || cnt_q == CNT_MAX)
         cnt_q <= '0;
      else
         cnt_q <= cnt_q + 1'b1;
   end

   assign sample = (cnt_q == CNT_MID);
   assign nrzi   = (line_state == prev_q);

   always_ff @(posedge clk) begin
      if (n_rst) begin
         state_q   <= IDLE;
         prev_q    <= LS_J;
         ones_q    <= '0;
         err_se0_q <= 1'b0;
         bit_q     <= 1'b0;
         valid_q   <= 1'b0;
         eop_q     <= 1'b0;
         serr_q    <= 1'b0;
         lerr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         prev_q    <= prev_d;
         ones_q    <= ones_d;
         err_se0_q <= err_se0_d;
         bit_q     <= bit_d;
         valid_q   <= valid_d;
         eop_q     <= eop_d;
         serr_q    <= serr_d;
         lerr_q    <= lerr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      prev_d    = prev_q;
      ones_d    = ones_q;
      err_se0_d = 1'b0;
      bit_d     = 1'b0;
      valid_d   = 1'b0;
      eop_d     = 1'b0;
      serr_d    = 1'b0;
      lerr_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            prev_d = LS_J;
            ones_d = '0;
            if (line_edge && line_state == LS_K)
               state_d = ACTIVE;
         end
         ACTIVE: begin
            if (sample) begin
               // SE0 is never NRZI-decoded, so it wins over stuffing.
               if (line_state == LS_SE0) begin
                  state_d = EOP1;
               end else if (line_state == LS_SE1) begin
                  lerr_d  = 1'b1;
                  state_d = ERROR;
               end else if (ones_q == ONES_LIM && nrzi) begin
                  serr_d  = 1'b1;
                  state_d = ERROR;
               end else if (ones_q == ONES_LIM) begin
                  prev_d = line_state;
                  ones_d = '0;
               end else begin
                  prev_d  = line_state;
                  valid_d = 1'b1;
                  bit_d   = nrzi;
                  ones_d  = nrzi ? ones_q + 1'b1 : '0;
               end
            end
         end
         EOP1: begin
            if (sample) begin
               if (line_state == LS_SE0) begin
                  state_d = EOP2;
               end else begin
                  lerr_d  = 1'b1;
                  state_d = ERROR;
               end
            end
         end
         EOP2: begin
            if (sample) begin
               if (line_state == LS_J) begin
                  eop_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  lerr_d  = 1'b1;
                  state_d = ERROR;
               end
            end
         end
         ERROR: begin
            err_se0_d = err_se0_q;
            if (sample) begin
               if (line_state == LS_SE0) begin
                  err_se0_d = 1'b1;
               end else if (line_state == LS_J && err_se0_q) begin
                  err_se0_d = 1'b0;
                  state_d   = IDLE;
               end else begin
                  err_se0_d = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign rx.bit_out     = bit_q;
   assign rx.bit_valid   = valid_q;
   assign rx.eop         = eop_q;
   assign rx.stuff_error = serr_q;
   assign rx.line_error  = lerr_q;
   assign rx.rx_active   = (state_q == ACTIVE) ||
                           (state_q == EOP1) ||
                           (state_q == EOP2);

endmodule

// File: tb/tb_usb_rx_bit_recovery.sv
// Directed bench for usb_rx_bit_recovery: line symbols in, strobed
// bits and framing pulses recorded at negedge and checked by assertion.
module tb_usb_rx_bit_recovery;

   logic clk = 1'b0;
   logic n_rst = 1'b1;
   logic dp = 1'b1;
   logic dm = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   usb_rx_bit_recovery_if rx ();

   usb_rx_bit_recovery #(
      .SAMPLES_PER_BIT (8),
      .STUFF_LIMIT     (6)
   ) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .d_plus_in  (dp),
      .d_minus_in (dm),
      .rx         (rx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   bit sb_bit[$];
   int sb_cyc[$];
   bit sb_act[$];
   int n_eop = 0;
   int n_serr = 0;
   int n_lerr = 0;
   int n_pulse_act = 0;
   int n_busy = 0;

   always @(negedge clk) begin
      if (rx.bit_valid) begin
         sb_bit.push_back(rx.bit_out);
         sb_cyc.push_back(cyc);
         sb_act.push_back(rx.rx_active);
      end
      if (rx.eop) n_eop++;
      if (rx.stuff_error) n_serr++;
      if (rx.line_error) n_lerr++;
      if ((rx.eop || rx.stuff_error || rx.line_error) && rx.rx_active)
         n_pulse_act++;
      if (rx.bit_out || rx.bit_valid || rx.rx_active || rx.eop ||
          rx.stuff_error || rx.line_error)
         n_busy++;
   end

   int b0, e0, s0, l0, p0, k0;

   task automatic mark();
      b0 = sb_bit.size();
      e0 = n_eop;
      s0 = n_serr;
      l0 = n_lerr;
      p0 = n_pulse_act;
      k0 = n_busy;
   endtask

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic sym(byte c, int n);
      case (c)
         "K":     {dp, dm} = 2'b01;
         "0":     {dp, dm} = 2'b00;
         "1":     {dp, dm} = 2'b11;
         default: {dp, dm} = 2'b10;
      endcase
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(string s);
      for (int i = 0; i < s.len(); i++) sym(s[i], 8);
   endtask

   function automatic logic [31:0] pack_bits(int base, int n);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < n; i++) begin
         v = v << 1;
         if (base + i < sb_bit.size()) v[0] = sb_bit[base + i];
      end
      return v;
   endfunction

   function automatic logic [5:0] outs();
      return {rx.bit_out, rx.bit_valid, rx.rx_active,
              rx.eop, rx.stuff_error, rx.line_error};
   endfunction

   initial begin
      int good;

      // reset and idle
      n_rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", 32'(outs()), 0);
      n_rst = 1'b0;
      mark();
      sym("J", 100);
      check("idle_busy", n_busy - k0, 0);
      check("idle_strobes", sb_bit.size() - b0, 0);

      // SYNC and EOP
      mark();
      send("KJKJKJKK00J");
      sym("J", 16);
      check("sync_count", sb_bit.size() - b0, 8);
      check("sync_bits", pack_bits(b0, 8), 32'h01);
      good = 0;
      for (int i = 1; i < 8; i++)
         if (b0 + i < sb_cyc.size() &&
             sb_cyc[b0 + i] - sb_cyc[b0 + i - 1] == 8) good++;
      check("sync_spacing", good, 7);
      good = 0;
      for (int i = b0; i < sb_act.size(); i++) good += int'(sb_act[i]);
      check("sync_active", good, 8);
      check("sync_eop", n_eop - e0, 1);
      check("sync_eop_active_low", n_pulse_act - p0, 0);
      check("sync_errors", (n_serr - s0) + (n_lerr - l0), 0);
      check("sync_idle_after", rx.rx_active, 0);

      // seven ones with a stuffed zero after the sixth
      mark();
      send("KJKJKJKKJJJJJJJKK00J");
      sym("J", 16);
      check("stuff_count", sb_bit.size() - b0, 16);
      check("stuff_bits", pack_bits(b0, 16), 32'h017F);
      check("stuff_no_error", n_serr - s0, 0);
      check("stuff_eop", n_eop - e0, 1);

      // seven ones without stuffing
      mark();
      send("KJKJKJKKJJJJJJJJ");
      send("KJKJ");
      check("viol_count", sb_bit.size() - b0, 15);
      check("viol_stuff_error", n_serr - s0, 1);
      check("viol_active_low", rx.rx_active, 0);
      send("0J");
      sym("J", 16);
      check("viol_no_more_bits", sb_bit.size() - b0, 15);
      check("viol_bits", pack_bits(b0, 15), 32'h00BF);
      check("viol_no_eop", n_eop - e0, 0);
      check("viol_pulse_active", n_pulse_act - p0, 0);
      check("viol_line_error", n_lerr - l0, 0);

      // SE1 mid packet
      mark();
      send("KJKJKJKKJK1JK0J");
      sym("J", 16);
      check("se1_count", sb_bit.size() - b0, 10);
      check("se1_bits", pack_bits(b0, 10), 32'h004);
      check("se1_line_error", n_lerr - l0, 1);
      check("se1_no_eop", n_eop - e0, 0);
      check("se1_pulse_active", n_pulse_act - p0, 0);
      check("se1_stuff", n_serr - s0, 0);

      // reset three bits into a packet
      mark();
      send("KJK");
      sym("J", 4);
      check("mid_active", rx.rx_active, 1);
      check("mid_bits", pack_bits(b0, 3), 32'h0);
      n_rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid_reset_outputs", 32'(outs()), 0);
      sym("J", 2);
      n_rst = 1'b0;
      sym("J", 16);
      check("mid_no_pulses",
            (n_eop - e0) + (n_serr - s0) + (n_lerr - l0), 0);
      mark();
      send("KJKJKJKK00J");
      sym("J", 16);
      check("post_reset_count", sb_bit.size() - b0, 8);
      check("post_reset_bits", pack_bits(b0, 8), 32'h01);
      check("post_reset_eop", n_eop - e0, 1);

      // jittered edges
      mark();
      sym("K", 10);
      sym("J", 6);
      sym("K", 6);
      sym("J", 10);
      sym("K", 8);
      sym("J", 6);
      sym("K", 16);
      sym("J", 10);
      sym("K", 6);
      sym("0", 16);
      sym("J", 24);
      check("jitter_count", sb_bit.size() - b0, 10);
      check("jitter_bits", pack_bits(b0, 10), 32'h004);
      check("jitter_eop", n_eop - e0, 1);
      check("jitter_errors", (n_serr - s0) + (n_lerr - l0), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
